// File: rtl/mantissa_nonrestoring_divider_if.sv
// Handshake bundle for the mantissa divider: operand request channel and result channel.
interface mantissa_nonrestoring_divider_if #(
   parameter int MAN_W = 11,
   parameter int QUO_W = MAN_W + 3
);
   logic             in_valid;
   logic             in_ready;
   logic [MAN_W-1:0] man_a;
   logic [MAN_W-1:0] man_b;
   logic             out_valid;
   logic             out_ready;
   logic [QUO_W-1:0] quotient;
   logic [MAN_W-1:0] remainder;
   logic             sticky;
   logic             div_by_zero;

   modport master (
      output in_valid, man_a, man_b, out_ready,
      input  in_ready, out_valid, quotient, remainder, sticky, div_by_zero
   );

   modport slave (
      input  in_valid, man_a, man_b, out_ready,
      output in_ready, out_valid, quotient, remainder, sticky, div_by_zero
   );
endinterface

// File: rtl/mantissa_nonrestoring_divider.sv
// Sequential non-restoring mantissa divider, one quotient bit per cycle, MSB first.
// Optional macro DIV_EARLY_TERM_EN: finish as soon as the partial remainder reaches zero.
module mantissa_nonrestoring_divider #(
   parameter int MAN_W = 11,
   parameter int QUO_W = MAN_W + 3
) (
   input logic                          clk,
   input logic                          rst,
   mantissa_nonrestoring_divider_if.slave bus
);
   localparam int P_W   = MAN_W + 2;
   localparam int CNT_W = $clog2(QUO_W);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]              state;
   logic [CNT_W-1:0]        cnt;
   logic signed [P_W-1:0]   p;
   logic signed [P_W-1:0]   p_new;
   logic signed [P_W-1:0]   p_fix;
   logic signed [P_W-1:0]   b_ext;
   logic [MAN_W-1:0]        b_reg;
   logic [QUO_W-1:0]        q_work;
   logic [QUO_W-1:0]        q_new;
   logic                    first_step;
   logic                    done_now;

   logic [QUO_W-1:0]        quo_r;
   logic [MAN_W-1:0]        rem_r;
   logic                    sticky_r;
   logic                    dbz_r;

   // The first step subtracts the divisor from the unshifted dividend; later steps shift first.
   function automatic logic signed [P_W-1:0] nr_step(
      input logic signed [P_W-1:0] pr,
      input logic signed [P_W-1:0] bx,
      input logic                  first
   );
      logic signed [P_W-1:0] base;
      base = first ? pr : (pr <<< 1);
      return (first || !pr[P_W-1]) ? (base - bx) : (base + bx);
   endfunction

   assign b_ext      = signed'({2'b00, b_reg});
   assign first_step = (cnt == CNT_W'(QUO_W - 1));
   assign p_new      = nr_step(p, b_ext, first_step);
   assign p_fix      = p_new[P_W-1] ? (p_new + b_ext) : p_new;

   // Quotient bits land at their final weight, so untouched low bits are already zero.
   always_comb begin
      q_new      = q_work;
      q_new[cnt] = ~p_new[P_W-1];
   end

`ifdef DIV_EARLY_TERM_EN
   assign done_now = (cnt == '0) || (p_new == '0);
`else
   assign done_now = (cnt == '0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         quo_r    <= '0;
         rem_r    <= '0;
         sticky_r <= 1'b0;
         dbz_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  cnt <= CNT_W'(QUO_W - 1);
                  if (bus.man_b == '0) begin
                     state    <= DONE;
                     quo_r    <= '1;
                     rem_r    <= '0;
                     sticky_r <= 1'b0;
                     dbz_r    <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               cnt <= cnt - 1'b1;
               if (done_now) begin
                  state    <= DONE;
                  quo_r    <= q_new;
                  rem_r    <= p_fix[MAN_W-1:0];
                  sticky_r <= (p_fix != '0);
                  dbz_r    <= 1'b0;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Working datapath needs no reset: it is fully loaded on every accept.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.in_valid) begin
         p      <= signed'({2'b00, bus.man_a});
         b_reg  <= bus.man_b;
         q_work <= '0;
      end else if (state == RUN) begin
         p      <= p_new;
         q_work <= q_new;
      end
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.quotient    = quo_r;
   assign bus.remainder   = rem_r;
   assign bus.sticky      = sticky_r;
   assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_mantissa_nonrestoring_divider.sv
// Scoreboard bench for mantissa_nonrestoring_divider: random and directed operands vs. floor/mod model.
module tb_mantissa_nonrestoring_divider;
   localparam int MAN_W = 11;
   localparam int QUO_W = 14;

   typedef struct {
      logic [QUO_W-1:0] q;
      logic [MAN_W-1:0] r;
      logic             s;
      logic             z;
      int               lat;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   fails;
   int   vectors;
   int   cyc;
   int   acc_cyc;
   int   ready_mode;
   logic prev_ov;
   exp_t sb[$];

   mantissa_nonrestoring_divider_if #(.MAN_W(MAN_W), .QUO_W(QUO_W)) bus ();

   mantissa_nonrestoring_divider #(.MAN_W(MAN_W), .QUO_W(QUO_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input int a, input int b);
      exp_t   e;
      longint num;
      int     k;
      num = longint'(a) <<< (QUO_W - 1);
      if (b == 0) begin
         e.q = '1; e.r = '0; e.s = 1'b0; e.z = 1'b1; e.lat = 1;
      end else begin
         e.q = QUO_W'(num / b);
         e.r = MAN_W'(num % b);
         e.s = (num % b) != 0;
         e.z = 1'b0;
         k = QUO_W;
`ifdef DIV_EARLY_TERM_EN
         for (int i = 1; i <= QUO_W; i++) begin
            if (((longint'(a) <<< (i - 1)) % b) == 0) begin
               k = i;
               break;
            end
         end
`endif
         e.lat = k + 1;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic issue(input int a, input int b);
      int t;
      t = 0;
      while (!bus.in_ready && t < 200) begin
         step();
         t++;
      end
      if (!bus.in_ready) begin
         fails++;
         $display("FAIL issue_timeout: in_ready stayed %b, expected 1", bus.in_ready);
         return;
      end
      bus.man_a    = MAN_W'(a);
      bus.man_b    = MAN_W'(b);
      bus.in_valid = 1'b1;
      sb.push_back(model(a, b));
      vectors++;
      step();
      bus.in_valid = 1'b0;
      bus.man_a    = MAN_W'($urandom);
      bus.man_b    = MAN_W'($urandom);
   endtask

   task automatic wait_valid(input string name);
      int t;
      t = 0;
      while (!bus.out_valid && t < 100) begin
         step();
         t++;
      end
      chk(name, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         step();
         t++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   // Edge counter and accept-edge timestamp
   initial begin
      cyc = 0;
      acc_cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst && bus.in_valid && bus.in_ready) acc_cyc = cyc;
      end
   end

   // Downstream ready generator
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: compares every presented result against the scoreboard head
   initial begin
      exp_t e;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output: got q=%h with empty scoreboard", bus.quotient);
            end else begin
               e = sb[0];
               if (!prev_ov) chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
               chk("quotient",    32'(bus.quotient),    32'(e.q));
               chk("remainder",   32'(bus.remainder),   32'(e.r));
               chk("sticky",      32'(bus.sticky),      32'(e.s));
               chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
               chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
               if (bus.out_ready) void'(sb.pop_front());
            end
         end
         prev_ov = rst ? 1'b0 : bus.out_valid;
      end
   end

   initial begin
      checks = 0; fails = 0; vectors = 0;
      ready_mode   = 1;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.man_a    = '0;
      bus.man_b    = '0;
      step(); step();
      chk("rst_in_ready",    32'(bus.in_ready),    32'd1);
      chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
      chk("rst_quotient",    32'(bus.quotient),    32'd0);
      chk("rst_remainder",   32'(bus.remainder),   32'd0);
      chk("rst_sticky",      32'(bus.sticky),      32'd0);
      chk("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
      rst = 1'b0;
      step();

      // Directed corner operands
      issue(11'h400, 11'h400);
      issue(11'h7FF, 11'h400);
      issue(11'h400, 11'h7FF);
      issue(11'h555, 11'h000);
      drain();

      // Backpressure with an ignored in_valid pulse during RUN
      ready_mode = 0;
      issue(11'h7FF, 11'h7FF);
      step(); step();
      bus.man_a = 11'h123; bus.man_b = 11'h456; bus.in_valid = 1'b1;
      step(); step();
      bus.in_valid = 1'b0;
      wait_valid("bp_out_valid_rise");
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready_low",   32'(bus.in_ready),  32'd0);
      end
      ready_mode = 1;
      step(); step();
      chk("release_in_ready",  32'(bus.in_ready),  32'd1);
      chk("release_out_valid", 32'(bus.out_valid), 32'd0);
      chk("hold_quotient",     32'(bus.quotient),  32'h2000);
      chk("bp_scoreboard",     32'(sb.size()),     32'd0);

      // Asynchronous reset in the middle of an operation
      issue(11'h600, 11'h500);
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      #1;
      chk("midrst_in_ready",    32'(bus.in_ready),    32'd1);
      chk("midrst_out_valid",   32'(bus.out_valid),   32'd0);
      chk("midrst_quotient",    32'(bus.quotient),    32'd0);
      chk("midrst_remainder",   32'(bus.remainder),   32'd0);
      chk("midrst_sticky",      32'(bus.sticky),      32'd0);
      chk("midrst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
      sb.delete();
      step();
      rst = 1'b0;
      step();
      issue(11'h600, 11'h500);
      drain();

      // Random normal operands with random downstream stalls
      ready_mode = 2;
      for (int n = 0; n < 2000; n++) begin
         int a;
         int b;
         a = int'($urandom_range(1024, 2047));
         b = ($urandom_range(0, 63) == 0) ? 0 : int'($urandom_range(1024, 2047));
         issue(a, b);
      end
      ready_mode = 1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
